// File: rtl/id_matcher_pkg.sv
// Shared types and defaults for the ID-entry matcher: FSM state encoding,
// the "no match" index helper and the factory ID table.
package id_match_pkg;

  typedef enum logic [2:0] {
    COLLECT,
    COMPARE,
    VERIFY,
    MATCHED,
    LOCKED
  } state_e;

  // All-ones index of the given width, used as the "no ID matched" code.
  function automatic logic [31:0] id_none(input int idx_w);
    return (32'd1 << idx_w) - 32'd1;
  endfunction

  // One 16-bit BCD word per ID; the leftmost nibble is the first keyed digit.
  localparam logic [4:0][15:0] DEFAULT_ID_TABLE = {
    16'h9876,  // ID4
    16'h0001,  // ID3
    16'h7777,  // ID2
    16'h1256,  // ID1
    16'h1234   // ID0
  };

endpackage

// File: rtl/id_matcher_if.sv
// Keypad-side and password-stage-side signals of the ID matcher, bundled
// so the keypad driver (master) and the matcher (slave) share one port.
interface id_matcher_if #(
  parameter int NUM_IDS   = 5,
  parameter int ID_DIGITS = 4,
  parameter int DIGIT_W   = 4
);
  localparam int IDX_W = $clog2(NUM_IDS + 1);

  logic                 digit_valid;
  logic [DIGIT_W-1:0]   digit_in;
  logic                 abort;
  logic                 check_password;
  logic [IDX_W-1:0]     matched_id;
  logic                 reject;
  logic [ID_DIGITS-1:0] progress_leds;
  logic                 locked;

  modport master (
    output digit_valid, digit_in, abort,
    input  check_password, matched_id, reject, progress_leds, locked
  );

  modport slave (
    input  digit_valid, digit_in, abort,
    output check_password, matched_id, reject, progress_leds, locked
  );
endinterface

// File: rtl/id_matcher_id_table.sv
// Constant ID table read one digit position at a time: all NUM_IDS digits
// for position addr_i come out in parallel one cycle after the address.
module id_table #(
  parameter int NUM_IDS   = 5,
  parameter int ID_DIGITS = 4,
  parameter int DIGIT_W   = 4,
  parameter int CNT_W     = 2,
  parameter logic [NUM_IDS-1:0][ID_DIGITS*DIGIT_W-1:0] TABLE = '0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [CNT_W-1:0]                  addr_i,
  output logic [NUM_IDS-1:0][DIGIT_W-1:0]   data_o
);

  logic [NUM_IDS-1:0][DIGIT_W-1:0] data_d, data_q;

  always_comb begin
    for (int i = 0; i < NUM_IDS; i++) begin
      data_d[i] = TABLE[i][(ID_DIGITS - 1 - int'(addr_i)) * DIGIT_W +: DIGIT_W];
    end
  end

  // NOTE: only the read register is reset; the table is a constant and has no state to clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) data_q <= '0;
    else      data_q <= data_d;
  end

  assign data_o = data_q;

endmodule

// File: rtl/id_matcher.sv
// Digit-by-digit ID matcher with early reject and held match result.
// Define ID_MATCHER_LOCKOUT_EN to add the failed-attempt counter and lockout.
module id_matcher
  import id_match_pkg::*;
#(
  parameter int NUM_IDS     = 5,
  parameter int ID_DIGITS   = 4,
  parameter int DIGIT_W     = 4,
  parameter int MAX_FAILS   = 3,
  parameter int LOCK_CYCLES = 16,
  parameter logic [NUM_IDS-1:0][ID_DIGITS*DIGIT_W-1:0] ID_TABLE = DEFAULT_ID_TABLE
) (
  input  logic         clk,
  input  logic         rst,
  id_matcher_if.slave  bus
);

  localparam int IDX_W = $clog2(NUM_IDS + 1);
  localparam int CNT_W = (ID_DIGITS > 1) ? $clog2(ID_DIGITS) : 1;
  localparam logic [IDX_W-1:0] ID_NONE    = IDX_W'(id_none(IDX_W));
  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(ID_DIGITS - 1);

  state_e                          state_q, state_d;
  logic [DIGIT_W-1:0]              digit_q, digit_d;
  logic [NUM_IDS-1:0]              match_vec_q, match_vec_d;
  logic [CNT_W-1:0]                digit_cnt_q, digit_cnt_d;
  logic [ID_DIGITS-1:0]            progress_q, progress_d;
  logic [IDX_W-1:0]                matched_q, matched_d;
  logic                            check_q, check_d;
  logic                            reject_q, reject_d;

  logic [NUM_IDS-1:0][DIGIT_W-1:0] rom_data;
  logic [NUM_IDS-1:0]              eq_vec, hit;
  logic [IDX_W-1:0]                first_idx;

`ifdef ID_MATCHER_LOCKOUT_EN
  localparam int FAIL_W = $clog2(MAX_FAILS + 1);
  localparam int LOCK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  logic [FAIL_W-1:0] fail_cnt_q, fail_cnt_d;
  logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
  logic              locked_q, locked_d;
`else
  logic unused_lock_cfg;
  assign unused_lock_cfg = ^{MAX_FAILS, LOCK_CYCLES};
`endif

  id_table #(
    .NUM_IDS   (NUM_IDS),
    .ID_DIGITS (ID_DIGITS),
    .DIGIT_W   (DIGIT_W),
    .CNT_W     (CNT_W),
    .TABLE     (ID_TABLE)
  ) u_id_table (
    .clk    (clk),
    .rst    (rst),
    .addr_i (digit_cnt_q),
    .data_o (rom_data)
  );

  always_comb begin
    for (int i = 0; i < NUM_IDS; i++) eq_vec[i] = (digit_q == rom_data[i]);
  end
  assign hit = match_vec_q & eq_vec;

  // Scan downward so the lowest surviving index wins on duplicate IDs.
  always_comb begin
    first_idx = ID_NONE;
    for (int i = NUM_IDS - 1; i >= 0; i--) begin
      if (match_vec_q[i]) first_idx = IDX_W'(i);
    end
  end

  always_comb begin
    // NOTE: every _d signal gets its hold/idle value first so no path through the case infers a latch.
    state_d     = state_q;
    digit_d     = digit_q;
    match_vec_d = match_vec_q;
    digit_cnt_d = digit_cnt_q;
    progress_d  = progress_q;
    matched_d   = matched_q;
    check_d     = 1'b0;
    reject_d    = 1'b0;
`ifdef ID_MATCHER_LOCKOUT_EN
    fail_cnt_d  = fail_cnt_q;
    lock_cnt_d  = lock_cnt_q;
    locked_d    = locked_q;
`endif

    if (bus.abort && state_q != LOCKED) begin
      state_d     = COLLECT;
      digit_d     = '0;
      match_vec_d = '1;
      digit_cnt_d = '0;
      progress_d  = '0;
      matched_d   = ID_NONE;
    end else begin
      case (state_q)
        COLLECT: begin
          if (bus.digit_valid) begin
            digit_d = bus.digit_in;
            state_d = COMPARE;
          end
        end
        COMPARE: begin
          if (hit == '0) begin
            // A rejected entry restarts with every ID back in the candidate set.
            reject_d    = 1'b1;
            match_vec_d = '1;
            digit_cnt_d = '0;
            progress_d  = '0;
`ifdef ID_MATCHER_LOCKOUT_EN
            if (int'(fail_cnt_q) < MAX_FAILS) fail_cnt_d = fail_cnt_q + 1'b1;
            if (int'(fail_cnt_q) + 1 == MAX_FAILS) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
            end else begin
              state_d = COLLECT;
            end
`else
            state_d = COLLECT;
`endif
          end else begin
            match_vec_d             = hit;
            progress_d[digit_cnt_q] = 1'b1;
            if (digit_cnt_q == LAST_DIGIT) begin
              state_d = VERIFY;
            end else begin
              digit_cnt_d = digit_cnt_q + 1'b1;
              state_d     = COLLECT;
            end
          end
        end
        VERIFY: begin
          check_d    = 1'b1;
          matched_d  = first_idx;
          progress_d = '0;
`ifdef ID_MATCHER_LOCKOUT_EN
          fail_cnt_d = '0;
`endif
          state_d    = MATCHED;
        end
        MATCHED: begin
          state_d = MATCHED;
        end
`ifdef ID_MATCHER_LOCKOUT_EN
        LOCKED: begin
          if (int'(lock_cnt_q) == LOCK_CYCLES - 1) begin
            lock_cnt_d = '0;
            fail_cnt_d = '0;
            locked_d   = 1'b0;
            state_d    = COLLECT;
          end else begin
            lock_cnt_d = lock_cnt_q + 1'b1;
          end
        end
`endif
        default: state_d = COLLECT;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= COLLECT;
      digit_q     <= '0;
      match_vec_q <= '1;
      digit_cnt_q <= '0;
      progress_q  <= '0;
      matched_q   <= ID_NONE;
      check_q     <= 1'b0;
      reject_q    <= 1'b0;
`ifdef ID_MATCHER_LOCKOUT_EN
      fail_cnt_q  <= '0;
      lock_cnt_q  <= '0;
      locked_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      digit_q     <= digit_d;
      match_vec_q <= match_vec_d;
      digit_cnt_q <= digit_cnt_d;
      progress_q  <= progress_d;
      matched_q   <= matched_d;
      check_q     <= check_d;
      reject_q    <= reject_d;
`ifdef ID_MATCHER_LOCKOUT_EN
      fail_cnt_q  <= fail_cnt_d;
      lock_cnt_q  <= lock_cnt_d;
      locked_q    <= locked_d;
`endif
    end
  end

  assign bus.check_password = check_q;
  assign bus.matched_id     = matched_q;
  assign bus.reject         = reject_q;
  assign bus.progress_leds  = progress_q;
`ifdef ID_MATCHER_LOCKOUT_EN
  assign bus.locked         = locked_q;
`else
  assign bus.locked         = 1'b0;
`endif

endmodule

// File: tb/tb_id_matcher.sv
// Directed bench for id_matcher with the default ID table
// (1234, 1256, 7777, 0001, 9876); expectations are hand-derived.
module tb_id_matcher;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  id_matcher_if #(.NUM_IDS(5), .ID_DIGITS(4), .DIGIT_W(4)) bus ();

  id_matcher #(
    .NUM_IDS     (5),
    .ID_DIGITS   (4),
    .DIGIT_W     (4),
    .MAX_FAILS   (3),
    .LOCK_CYCLES (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle strobe, then the compare edge; returns just after the compare result registers.
  task automatic key(input logic [3:0] d);
    bus.digit_in    = d;
    bus.digit_valid = 1'b1;
    tick();
    bus.digit_valid = 1'b0;
    tick();
  endtask

  task automatic do_abort();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
  endtask

  initial begin
    logic [3:0] seq_a [4];
    logic [3:0] seq_b [4];
    logic [3:0] led_exp [4];
    tests = 0;
    fails = 0;
    seq_a   = '{4'd1, 4'd2, 4'd5, 4'd6};
    seq_b   = '{4'd9, 4'd8, 4'd7, 4'd6};
    led_exp = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};

    rst             = 1'b0;
    bus.digit_valid = 1'b0;
    bus.digit_in    = '0;
    bus.abort       = 1'b0;
    tick();
    tick();
    check("rst_check", bus.check_password, 0);
    check("rst_id",    bus.matched_id,     7);
    check("rst_rej",   bus.reject,         0);
    check("rst_leds",  bus.progress_leds,  0);
    check("rst_lock",  bus.locked,         0);
    rst = 1'b1;
    tick();

    // Reset while the second digit is in COMPARE.
    key(4'd1);
    check("pre_rst_leds", bus.progress_leds, 4'b0001);
    bus.digit_in    = 4'd2;
    bus.digit_valid = 1'b1;
    tick();
    bus.digit_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("midrst_leds", bus.progress_leds,  0);
    check("midrst_id",   bus.matched_id,     7);
    check("midrst_chk",  bus.check_password, 0);
    check("midrst_rej",  bus.reject,         0);
    tick();
    rst = 1'b1;
    tick();
    key(4'd1);
    check("postrst_leds", bus.progress_leds, 4'b0001);
    do_abort();
    tick();

    // 1,2,3,9: ID0 survives three digits, then fails on the fourth.
    key(4'd1);
    key(4'd2);
    key(4'd3);
    check("rej_leds3", bus.progress_leds, 4'b0111);
    key(4'd9);
    check("rej_pulse",  bus.reject,        1);
    check("rej_leds",   bus.progress_leds, 0);
    check("rej_id",     bus.matched_id,    7);
    tick();
    check("rej_pulse_end", bus.reject, 0);

    // 1,2,5,6 at 4-cycle spacing matches ID1.
    for (int k = 0; k < 4; k++) begin
      key(seq_a[k]);
      check($sformatf("m1_leds%0d", k), bus.progress_leds, led_exp[k]);
      check($sformatf("m1_rej%0d", k),  bus.reject,        0);
      if (k < 3) begin
        tick();
        tick();
      end
    end
    check("m1_chk_early", bus.check_password, 0);
    tick();
    check("m1_chk",       bus.check_password, 1);
    check("m1_id",        bus.matched_id,     1);
    check("m1_leds_clr",  bus.progress_leds,  0);
    tick();
    check("m1_chk_end",   bus.check_password, 0);
    key(4'd9);
    tick();
    tick();
    check("m1_id_held",   bus.matched_id,     1);
    check("m1_leds_held", bus.progress_leds,  0);
    do_abort();
    check("m1_abort_id",  bus.matched_id,     7);
    tick();

    // Three wrong first digits in a row.
    for (int k = 0; k < 3; k++) begin
      key(4'd8);
      check($sformatf("lk_rej%0d", k), bus.reject, 1);
    end
`ifdef ID_MATCHER_LOCKOUT_EN
    for (int i = 0; i < 16; i++) begin
      check($sformatf("lk_on%0d", i), bus.locked, 1);
      bus.digit_in    = 4'd1;
      bus.digit_valid = (i == 5);
      if (i == 9) bus.abort = 1'b1;
      tick();
      bus.digit_valid = 1'b0;
      bus.abort       = 1'b0;
    end
    check("lk_off",      bus.locked,        0);
    check("lk_leds",     bus.progress_leds, 0);
`else
    for (int i = 0; i < 4; i++) begin
      check($sformatf("nolk%0d", i), bus.locked, 0);
      tick();
    end
`endif

    // 9,8,7,6 matches ID4.
    for (int k = 0; k < 4; k++) begin
      key(seq_b[k]);
      check($sformatf("m4_leds%0d", k), bus.progress_leds, led_exp[k]);
    end
    tick();
    check("m4_chk", bus.check_password, 1);
    check("m4_id",  bus.matched_id,     4);
    do_abort();
    tick();

    // Abort together with the third strobe: digit is not consumed.
    key(4'd1);
    key(4'd2);
    check("ab_leds2", bus.progress_leds, 4'b0011);
    bus.digit_in    = 4'd5;
    bus.digit_valid = 1'b1;
    bus.abort       = 1'b1;
    tick();
    bus.digit_valid = 1'b0;
    bus.abort       = 1'b0;
    check("ab_leds",  bus.progress_leds, 0);
    check("ab_id",    bus.matched_id,    7);
    tick();
    check("ab_rej",   bus.reject,        0);
    check("ab_leds_b", bus.progress_leds, 0);
    key(4'd1);
    check("ab_restart", bus.progress_leds, 4'b0001);
    do_abort();
    tick();

    // Back-to-back strobes: the second lands in COMPARE and is dropped.
    bus.digit_in    = 4'd1;
    bus.digit_valid = 1'b1;
    tick();
    bus.digit_in    = 4'd2;
    tick();
    bus.digit_valid = 1'b0;
    check("bb_leds1", bus.progress_leds, 4'b0001);
    tick();
    check("bb_leds1b", bus.progress_leds, 4'b0001);
    key(4'd2);
    check("bb_leds2", bus.progress_leds, 4'b0011);
    check("bb_rej",   bus.reject,        0);
    key(4'd5);
    key(4'd6);
    tick();
    check("bb_chk",   bus.check_password, 1);
    check("bb_id",    bus.matched_id,     1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
